// File: rtl/azpr_vector_sampler.sv
`default_nettype none
// azpr_vector_sampler: samples synchronised pad vectors inside a timer window,
// timestamps them and streams {timestamp, vector} records from a FIFO over valid/ready.
module azpr_vector_sampler #(
   parameter int CH_NUM     = 4,
   parameter int TS_W       = 32,
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   mode,
   input  logic [DIV_W-1:0]       div,
   input  logic [TS_W-1:0]        win_start,
   input  logic [TS_W-1:0]        win_stop,
   input  logic [CH_NUM-1:0]      pad_in,
   output logic [TS_W+CH_NUM-1:0] rec_data,
   output logic                   rec_valid,
   input  logic                   rec_ready,
   output logic                   active,
   output logic                   overflow,
   output logic [15:0]            drop_cnt
);
   localparam int REC_W = TS_W + CH_NUM;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, CAPT, DONE} state_t;
   state_t state, state_nx;

   logic [CH_NUM-1:0] sync1, sync2, last_vec;
   logic [TS_W-1:0]   timer;
   logic [DIV_W-1:0]  div_cnt;
   logic              en_d, seen;
   logic [REC_W-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;

   logic tick, rise, sample_ev, first, push_req, full, pop, push_ok, drop;

   assign tick      = en & (div_cnt == div);
   assign active    = en & (timer >= win_start) & (timer < win_stop);
   assign rise      = en & ~en_d;
   // DONE latches the end of the window even if the window registers move later.
   assign sample_ev = tick & active & (state != DONE);
   assign first     = rise | ~seen;
   assign push_req  = sample_ev & (~mode | first | (sync2 != last_vec));
   assign full      = (count == CNT_FULL);
   assign rec_valid = (count != '0);
   assign pop       = rec_valid & rec_ready;
   assign push_ok   = push_req & (~full | pop);
   assign drop      = push_req & ~push_ok;
   assign rec_data  = rec_valid ? mem[rd_ptr] : '0;

   always_comb begin
      state_nx = state;
      if (!en) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE: state_nx = WAIT;
            WAIT: begin
               if (timer >= win_stop)       state_nx = DONE;
               else if (timer >= win_start) state_nx = CAPT;
            end
            CAPT: if (timer >= win_stop) state_nx = DONE;
            DONE: state_nx = DONE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         sync1    <= '0;
         sync2    <= '0;
         last_vec <= '0;
         timer    <= '0;
         div_cnt  <= '0;
         en_d     <= 1'b0;
         seen     <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state <= state_nx;
         sync1 <= pad_in;
         sync2 <= sync1;
         en_d  <= en;

         if (!en)                timer <= '0;
         else if (timer != '1)   timer <= timer + TS_W'(1);

         if (!en || tick) div_cnt <= '0;
         else             div_cnt <= div_cnt + DIV_W'(1);

         if (rise)           seen <= sample_ev;
         else if (sample_ev) seen <= 1'b1;

         if (push_req) last_vec <= sync2;

         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         unique case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase

         // A new session clears the loss statistics, but a drop in that same cycle still counts.
         if (rise) begin
            overflow <= drop;
            drop_cnt <= {15'd0, drop};
         end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {timer, sync2};
   end
endmodule
`default_nettype wire
